// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and line-level constants for the product UART transmitter.
//   uart_tx_state_t : frame state machine encoding
//   UART_IDLE_LVL   : level of an idle line (also the stop-bit level)
//   UART_START_LVL  : level of the start bit
//   UART_STOP_BITS  : number of stop bits appended to every frame
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam int   UART_STOP_BITS = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// ----------------------------------------------------------------------------
// uart_baud_gen
// Divides the system clock down to the serial bit period.
// Ports:
//   CLK         in  : system clock, rising edge
//   rst_n       in  : asynchronous active-low reset
//   restart     in  : zero the count so the next cycle is the first of a bit
//   bit_end     out : high on the last cycle of every bit
//   bit_pre_end out : high on the second-to-last cycle of every bit, used to
//                     register pulses that must line up with bit_end
// ----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt;

    // Free-running bit counter; restart takes priority so a new frame always
    // begins a full bit period after the shifter is loaded.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end     = (cnt == CNT_LAST);
    assign bit_pre_end = (cnt == CNT_PRE);

endmodule

// File: rtl/product_uart_tx.sv
// ----------------------------------------------------------------------------
// product_uart_tx
// Serial output stage for the multiplier datapath. Accepts 8-bit products over
// valid/ready, buffers one pending value and sends it as a UART frame:
// start bit, data LSB first, optional even parity, one stop bit.
// Optional feature macro: PRODUCT_UART_PARITY_EN (adds the even-parity bit).
// Ports:
//   CLK        in  : system clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   in_valid   in  : in_data holds a product
//   in_data    in  : product value (DATA_W bits)
//   in_ready   out : holding register empty (registered)
//   tx         out : serial line, idles high (registered)
//   busy       out : frame state machine not in IDLE (registered)
//   frame_done out : one-cycle pulse on the last cycle of the stop bit
// ----------------------------------------------------------------------------
module product_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(UART_STOP_BITS - 1);

    uart_tx_state_t    state;
    uart_tx_state_t    state_next;
    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] shifter;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_next;
    logic              load;
    logic              shift;
    logic              tx_next;
    logic              busy_next;
    logic              frame_done_next;
    logic              bit_end;
    logic              bit_pre_end;
    logic              handshake;
`ifdef PRODUCT_UART_PARITY_EN
    logic              parity_q;
`endif

    assign handshake = in_valid && in_ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .restart    (load),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    // Holding register. in_ready follows the previous hold_full, so it only
    // reopens one edge after the state machine drains the entry; it is also
    // forced low on the accepting edge so a second value cannot slip in.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            in_ready  <= 1'b1;
        end else begin
            if (handshake) begin
                hold_full <= 1'b1;
                hold_data <= in_data;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            in_ready <= !hold_full && !handshake;
        end
    end

    // Frame registers. tx is reset straight to the idle level so an abort
    // mid-frame releases the line without waiting for a clock.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shifter    <= '0;
            tx         <= UART_IDLE_LVL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef PRODUCT_UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            bit_idx    <= bit_idx_next;
            tx         <= tx_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
            if (load) begin
                shifter  <= hold_data;
`ifdef PRODUCT_UART_PARITY_EN
                parity_q <= ^hold_data;
`endif
            end else if (shift) begin
                shifter <= {1'b0, shifter[DATA_W-1:1]};
            end
        end
    end

    // Next-state logic. tx_next is the level of the bit that starts on the
    // coming edge, which keeps tx a clean register output.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        tx_next      = tx;
        load         = 1'b0;
        shift        = 1'b0;
        case (state)
            IDLE: begin
                tx_next = UART_IDLE_LVL;
                if (hold_full) begin
                    load         = 1'b1;
                    state_next   = START;
                    tx_next      = UART_START_LVL;
                    bit_idx_next = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    tx_next      = shifter[0];
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_DATA_IDX) begin
                        bit_idx_next = '0;
`ifdef PRODUCT_UART_PARITY_EN
                        state_next   = PARITY;
                        tx_next      = parity_q;
`else
                        state_next   = STOP;
                        tx_next      = UART_IDLE_LVL;
`endif
                    end else begin
                        shift        = 1'b1;
                        bit_idx_next = bit_idx + IDX_W'(1);
                        tx_next      = shifter[1];
                    end
                end
            end
`ifdef PRODUCT_UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next   = STOP;
                    tx_next      = UART_IDLE_LVL;
                    bit_idx_next = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_idx != LAST_STOP_IDX) begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end else if (hold_full) begin
                        load         = 1'b1;
                        state_next   = START;
                        tx_next      = UART_START_LVL;
                        bit_idx_next = '0;
                    end else begin
                        state_next   = IDLE;
                        tx_next      = UART_IDLE_LVL;
                        bit_idx_next = '0;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                tx_next      = UART_IDLE_LVL;
                bit_idx_next = '0;
            end
        endcase
        busy_next       = (state_next != IDLE);
        frame_done_next = (state == STOP) && bit_pre_end && (bit_idx == LAST_STOP_IDX);
    end

endmodule

// File: tb/tb_product_uart_tx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_product_uart_tx
// Self-checking bench for product_uart_tx. Stimulus pushes the expected
// (data, parity) of each accepted product into a queue; an independent line
// monitor decodes tx at bit centres and compares every received frame.
// ----------------------------------------------------------------------------
module tb_product_uart_tx;

    localparam int P    = 10;
    localparam int HALF = 5;
    localparam int CPB  = 4;
    localparam int NV   = 10;
`ifdef PRODUCT_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    localparam logic [7:0] VDATA [NV] = '{8'h62, 8'hFF, 8'h00, 8'hA5, 8'h01,
                                          8'h80, 8'h3C, 8'h5B, 8'h7E, 8'hC3};
    localparam logic       VPAR  [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                          1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } vecT;

    logic       CLK;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int    compared;
    int    mismatched;
    vecT   expQ[$];
    time   startLog[$];
    time   doneLog[$];
    bit    rxActive;
    int    rxCycle;
    logic [10:0] rxFrame;

    product_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8)
    ) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // Free-running system clock.
    initial CLK = 1'b0;
    always #HALF CLK = ~CLK;

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected frame as seen on the line, bit 0 = start bit.
    function automatic logic [10:0] expectedFrame(input vecT v);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = v.data;
`ifdef PRODUCT_UART_PARITY_EN
        f[9]   = v.par;
`endif
        return f;
    endfunction

    // Called at a negedge: present a vector and wait for in_ready, then
    // record the accepting edge and queue the expected frame. in_valid is
    // left high so callers can chain transfers without a gap.
    task automatic applyStimulus(input int idx, output time hsTime);
        int  guard;
        bit  done;
        vecT v;
        guard    = 0;
        done     = 1'b0;
        hsTime   = 0;
        v.data   = VDATA[idx];
        v.par    = VPAR[idx];
        in_valid = 1'b1;
        in_data  = VDATA[idx];
        while (!done && guard < 200) begin
            if (in_ready === 1'b1) begin
                @(posedge CLK);
                hsTime = $time;
                expQ.push_back(v);
                done = 1'b1;
            end else begin
                @(negedge CLK);
                guard++;
            end
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL handshake_timeout: in_ready=%0b, expected 1 within 200 cycles", in_ready);
        end
    endtask

    // Line must stay at the idle level for n consecutive cycles.
    task automatic idleCheck(input string name, input int n);
        logic allHigh;
        allHigh = 1'b1;
        repeat (n) begin
            @(negedge CLK);
            if (tx !== 1'b1) allHigh = 1'b0;
        end
        checkOutput(name, 32'(allHigh), 32'd1);
    endtask

    // Wait (bounded) until every queued frame has been received.
    task automatic waitDrain();
        for (int i = 0; i < 3000; i++) begin
            if (expQ.size() == 0 && !rxActive) break;
            @(negedge CLK);
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        repeat (4) @(negedge CLK);
    endtask

    // Line monitor: finds the start bit, samples each bit at its centre,
    // checks frame_done lines up with the final cycle, and compares against
    // the head of the expected queue.
    initial begin
        vecT expV;
        rxActive = 1'b0;
        rxCycle  = 0;
        rxFrame  = '1;
        forever begin
            @(negedge CLK);
            if (!rst_n) begin
                rxActive = 1'b0;
            end else begin
                if (frame_done === 1'b1) begin
                    doneLog.push_back($time - HALF);
                end
                if (!rxActive) begin
                    if (tx === 1'b0) begin
                        rxActive = 1'b1;
                        rxCycle  = 0;
                        rxFrame  = '1;
                        startLog.push_back($time - HALF);
                    end
                end else begin
                    rxCycle++;
                end
                if (rxActive) begin
                    if (rxCycle % CPB == CPB / 2) begin
                        rxFrame[4'(rxCycle / CPB)] = tx;
                    end
                    if (rxCycle == FRAME_CYC - 2) begin
                        checkOutput("frame_done_early", 32'(frame_done), 32'd0);
                    end
                    if (rxCycle == FRAME_CYC - 1) begin
                        checkOutput("frame_done_last", 32'(frame_done), 32'd1);
                        if (expQ.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("[TB] FAIL unexpected_frame: got frame 0x%0h, expected none", rxFrame);
                        end else begin
                            expV = expQ.pop_front();
                            checkOutput("frame", 32'(rxFrame), 32'(expectedFrame(expV)));
                        end
                        rxActive = 1'b0;
                    end
                end
            end
        end
    end

    // Safety net so the run always ends with a summary.
    initial begin
        #(20000 * P);
        mismatched++;
        $display("[TB] FAIL watchdog: simulation time %0t, expected completion earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Directed test sequence.
    initial begin
        time hsT;
        time hsT2;
        int  accepted;
        int  idx;
        int  guard;
        int  deltaT;
        vecT v;

        compared   = 0;
        mismatched = 0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        rst_n      = 1'b0;

        // Reset values and a quiet idle line.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        idleCheck("idle_no_input", 20);

        // Isolated frames: start latency, frame length and idle return.
        for (int i = 0; i < NV; i++) begin
            startLog.delete();
            doneLog.delete();
            applyStimulus(i, hsT);
            @(negedge CLK);
            in_valid = 1'b0;
            @(negedge CLK);
            checkOutput("busy_in_frame", 32'(busy), 32'd1);
            waitDrain();
            deltaT = (startLog.size() > 0) ? int'(startLog[0] - hsT) : 0;
            checkOutput("start_latency", 32'(deltaT), 32'(P));
            deltaT = (startLog.size() > 0 && doneLog.size() > 0) ? int'(doneLog[0] - startLog[0]) : 0;
            checkOutput("done_offset", 32'(deltaT), 32'((FRAME_CYC - 1) * P));
            checkOutput("busy_after_frame", 32'(busy), 32'd0);
            checkOutput("ready_after_frame", 32'(in_ready), 32'd1);
        end

        // Back-to-back: second product accepted during the first frame and
        // sent with no idle gap.
        startLog.delete();
        doneLog.delete();
        applyStimulus(0, hsT);
        @(negedge CLK);
        in_data = VDATA[1];
        checkOutput("ready_after_hs", 32'(in_ready), 32'd0);
        @(negedge CLK);
        checkOutput("ready_at_load", 32'(in_ready), 32'd0);
        @(negedge CLK);
        checkOutput("ready_after_load", 32'(in_ready), 32'd1);
        applyStimulus(1, hsT2);
        @(negedge CLK);
        in_valid = 1'b0;
        checkOutput("ready_while_full", 32'(in_ready), 32'd0);
        repeat (20) @(negedge CLK);
        checkOutput("ready_held_full", 32'(in_ready), 32'd0);
        waitDrain();
        deltaT = (startLog.size() > 1 && doneLog.size() > 0) ? int'(startLog[1] - doneLog[0]) : 0;
        checkOutput("b2b_gap", 32'(deltaT), 32'(P));

        // Reset during data bit 3 with a second value pending.
        applyStimulus(3, hsT);
        @(negedge CLK);
        applyStimulus(6, hsT2);
        @(negedge CLK);
        in_valid = 1'b0;
        while ($time < hsT + 18 * P + HALF) @(negedge CLK);
        checkOutput("tx_data_bit3", 32'(tx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("tx_async_reset", 32'(tx), 32'd1);
        checkOutput("busy_async_reset", 32'(busy), 32'd0);
        checkOutput("ready_async_reset", 32'(in_ready), 32'd1);
        expQ.delete();
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        idleCheck("idle_after_reset", 60);
        checkOutput("busy_after_reset", 32'(busy), 32'd0);

        // Backpressure: data changes every cycle, only accepted values count.
        accepted = 0;
        idx      = 0;
        guard    = 0;
        while (accepted < 3 && guard < 1000) begin
            in_valid = 1'b1;
            in_data  = VDATA[idx];
            if (in_ready === 1'b1) begin
                @(posedge CLK);
                v.data = VDATA[idx];
                v.par  = VPAR[idx];
                expQ.push_back(v);
                accepted++;
            end
            @(negedge CLK);
            idx = (idx + 1) % NV;
            guard++;
        end
        in_valid = 1'b0;
        checkOutput("bp_accepted", 32'(accepted), 32'd3);
        waitDrain();
        idleCheck("idle_final", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
